// File: rtl/fpu_pkg.sv
// ---------------------------------------------------------------------------
// fpu_pkg
// Shared constants and types for the single-precision add/sub datapath.
// Used by the pre-add alignment stage and the post-add normalisation logic.
//   EXP_W / MAN_W : exponent and stored-fraction widths (IEEE-754 single)
//   BIAS          : exponent bias
//   GRS_W         : guard/round/sticky bits appended below the mantissa
//   fp_unpacked_t : {sign, exp, mantissa including hidden bit}
//   fp_class_e    : operand class used for special-value detection
// ---------------------------------------------------------------------------
package fpu_pkg;

  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int BIAS  = 127;
  localparam int GRS_W = 3;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W:0]   mant;
  } fp_unpacked_t;

  typedef enum logic [2:0] {
    FP_ZERO   = 3'd0,
    FP_DENORM = 3'd1,
    FP_NORMAL = 3'd2,
    FP_INF    = 3'd3,
    FP_NAN    = 3'd4
  } fp_class_e;

endpackage

// File: rtl/align_rshift_sticky.sv
// ---------------------------------------------------------------------------
// align_rshift_sticky
// Combinational right shifter with sticky reduction. Every bit that falls
// off the bottom of the W-bit window is ORed into bit 0 of the result, so
// the lowest bit acts as the sticky bit. Shifts of W or more flush the
// whole word into the sticky position. Shared with the normalisation
// right-shift path.
// Ports:
//   data_in  [W-1:0]   value to shift
//   shamt    [SHW-1:0] right-shift amount
//   data_out [W-1:0]   shifted value with sticky in bit 0
// ---------------------------------------------------------------------------
module align_rshift_sticky
  import fpu_pkg::*;
#(
  parameter int W   = fpu_pkg::MAN_W + fpu_pkg::GRS_W + 1,
  parameter int SHW = fpu_pkg::EXP_W
) (
  input  logic [W-1:0]   data_in,
  input  logic [SHW-1:0] shamt,
  output logic [W-1:0]   data_out
);

  logic [2*W-1:0] wide;
  logic           sticky;
  logic           flush;

  // The input is placed in the upper half of a double-width word so that a
  // single shift yields both the kept bits (upper half) and the bits that
  // were shifted out (lower half), which are reduced to the sticky bit.
  always_comb begin
    wide   = {data_in, {W{1'b0}}} >> shamt;
    sticky = |wide[W-1:0];
    flush  = (32'(shamt) >= 32'(W));
    if (flush) begin
      data_out = {{(W-1){1'b0}}, |data_in};
    end else begin
      data_out = {wide[2*W-1:W+1], wide[W] | sticky};
    end
  end

endmodule

// File: rtl/fp_align_stage.sv
// ---------------------------------------------------------------------------
// fp_align_stage
// Pre-add operand alignment for the FPU add/sub datapath. Stage 1 unpacks
// both operands and orders them by magnitude; stage 2 right-shifts the
// smaller mantissa by the exponent difference, producing G/R/S bits.
// Two-stage valid/ready pipeline, one result per cycle, strict FIFO order.
//
// Optional build macro FP_ALIGN_SPECIAL_EN adds NaN/Inf/zero flags that
// travel with the data. Without it, all-ones exponents align as ordinary
// numbers.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   operand handshake
//   op_a, op_b            IEEE-754 packed operands
//   out_valid / out_ready result handshake
//   big_sign, small_sign  signs of larger / smaller magnitude operand
//   exp_out               effective exponent of the larger operand
//   big_mant              larger mantissa including hidden bit
//   small_mant            aligned smaller mantissa {hidden, frac, G, R, S}
//   swapped               B was strictly larger than A
//   eff_sub               big_sign ^ small_sign
//   is_nan, is_inf, is_zero (FP_ALIGN_SPECIAL_EN only) special-value flags
// ---------------------------------------------------------------------------
module fp_align_stage
  import fpu_pkg::*;
#(
  parameter int EXP_W = fpu_pkg::EXP_W,
  parameter int MAN_W = fpu_pkg::MAN_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   op_a,
  input  logic [EXP_W+MAN_W:0]   op_b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   big_sign,
  output logic                   small_sign,
  output logic [EXP_W-1:0]       exp_out,
  output logic [MAN_W:0]         big_mant,
  output logic [MAN_W+3:0]       small_mant,
  output logic                   swapped,
  output logic                   eff_sub
`ifdef FP_ALIGN_SPECIAL_EN
  ,
  output logic                   is_nan,
  output logic                   is_inf,
  output logic                   is_zero
`endif
);

  localparam int SW = MAN_W + GRS_W + 1;

  // Same shape as fpu_pkg::fp_unpacked_t but sized by this module's
  // parameters so that non-default widths stay consistent.
  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W:0]   mant;
  } op_t;

  logic             s1_adv;
  logic             s2_adv;

  op_t              a_u;
  op_t              b_u;
  op_t              big_u;
  op_t              small_u;
  logic             b_gt_a;
  logic [EXP_W-1:0] diff;

  logic             s1_valid;
  logic             s1_big_sign;
  logic             s1_small_sign;
  logic [EXP_W-1:0] s1_exp;
  logic [MAN_W:0]   s1_big_mant;
  logic [MAN_W:0]   s1_small_mant;
  logic [EXP_W-1:0] s1_diff;
  logic             s1_swapped;

  logic [SW-1:0]    aligned;

  // Backpressure ripples from the output towards the input in the same
  // cycle, so a full pipeline can still accept a new pair while it emits.
  assign s2_adv   = !out_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = s1_adv;

  // Unpack both operands. A zero exponent field means a denormal, which
  // sits at effective exponent 1 with no hidden bit. The magnitude compare
  // includes the hidden bit so a denormal never outranks an exponent-1
  // normal; ties keep A as the larger operand.
  always_comb begin
    a_u.sign = op_a[EXP_W+MAN_W];
    b_u.sign = op_b[EXP_W+MAN_W];
    a_u.exp  = (op_a[EXP_W+MAN_W-1:MAN_W] == '0) ? EXP_W'(1) : op_a[EXP_W+MAN_W-1:MAN_W];
    b_u.exp  = (op_b[EXP_W+MAN_W-1:MAN_W] == '0) ? EXP_W'(1) : op_b[EXP_W+MAN_W-1:MAN_W];
    a_u.mant = {|op_a[EXP_W+MAN_W-1:MAN_W], op_a[MAN_W-1:0]};
    b_u.mant = {|op_b[EXP_W+MAN_W-1:MAN_W], op_b[MAN_W-1:0]};
    b_gt_a   = {b_u.exp, b_u.mant} > {a_u.exp, a_u.mant};
    big_u    = b_gt_a ? b_u : a_u;
    small_u  = b_gt_a ? a_u : b_u;
    diff     = big_u.exp - small_u.exp;
  end

  // Stage 1 register: ordered operands and the alignment distance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid      <= 1'b0;
      s1_big_sign   <= 1'b0;
      s1_small_sign <= 1'b0;
      s1_exp        <= '0;
      s1_big_mant   <= '0;
      s1_small_mant <= '0;
      s1_diff       <= '0;
      s1_swapped    <= 1'b0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_big_sign   <= big_u.sign;
        s1_small_sign <= small_u.sign;
        s1_exp        <= big_u.exp;
        s1_big_mant   <= big_u.mant;
        s1_small_mant <= small_u.mant;
        s1_diff       <= diff;
        s1_swapped    <= b_gt_a;
      end
    end
  end

  align_rshift_sticky #(
    .W   (SW),
    .SHW (EXP_W)
  ) u_shift (
    .data_in  ({s1_small_mant, {GRS_W{1'b0}}}),
    .shamt    (s1_diff),
    .data_out (aligned)
  );

  // Stage 2 register: these flops are the module outputs, so they only
  // change when the downstream side has taken the previous result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      big_sign   <= 1'b0;
      small_sign <= 1'b0;
      exp_out    <= '0;
      big_mant   <= '0;
      small_mant <= '0;
      swapped    <= 1'b0;
      eff_sub    <= 1'b0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        big_sign   <= s1_big_sign;
        small_sign <= s1_small_sign;
        exp_out    <= s1_exp;
        big_mant   <= s1_big_mant;
        small_mant <= aligned;
        swapped    <= s1_swapped;
        eff_sub    <= s1_big_sign ^ s1_small_sign;
      end
    end
  end

`ifdef FP_ALIGN_SPECIAL_EN
  fp_class_e a_cls;
  fp_class_e b_cls;
  logic      sp_nan;
  logic      sp_inf;
  logic      sp_zero;
  logic      s1_nan;
  logic      s1_inf;
  logic      s1_zero;

  function automatic fp_class_e classify(input logic [EXP_W-1:0] e,
                                         input logic [MAN_W-1:0] f);
    if (&e)           return (|f) ? FP_NAN : FP_INF;
    else if (e == '0) return (|f) ? FP_DENORM : FP_ZERO;
    else              return FP_NORMAL;
  endfunction

  // Special classes are decided on the raw fields; Inf minus Inf under an
  // effective subtract has no defined result and is reported as NaN.
  always_comb begin
    a_cls   = classify(op_a[EXP_W+MAN_W-1:MAN_W], op_a[MAN_W-1:0]);
    b_cls   = classify(op_b[EXP_W+MAN_W-1:MAN_W], op_b[MAN_W-1:0]);
    sp_nan  = (a_cls == FP_NAN) || (b_cls == FP_NAN) ||
              ((a_cls == FP_INF) && (b_cls == FP_INF) &&
               (op_a[EXP_W+MAN_W] ^ op_b[EXP_W+MAN_W]));
    sp_inf  = ((a_cls == FP_INF) || (b_cls == FP_INF)) && !sp_nan;
    sp_zero = (a_cls == FP_ZERO) && (b_cls == FP_ZERO);
  end

  // Flags ride the same enables as the data so they stay paired with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_nan  <= 1'b0;
      s1_inf  <= 1'b0;
      s1_zero <= 1'b0;
      is_nan  <= 1'b0;
      is_inf  <= 1'b0;
      is_zero <= 1'b0;
    end else begin
      if (s1_adv && in_valid) begin
        s1_nan  <= sp_nan;
        s1_inf  <= sp_inf;
        s1_zero <= sp_zero;
      end
      if (s2_adv && s1_valid) begin
        is_nan  <= s1_nan;
        is_inf  <= s1_inf;
        is_zero <= s1_zero;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fp_align_stage.sv
// ---------------------------------------------------------------------------
// tb_fp_align_stage
// Directed self-checking bench for fp_align_stage: reset state, basic
// alignment, swap, sticky generation, flush, effective subtract, back-to-back
// throughput, backpressure with hold/ordering, and asynchronous reset with
// both stages occupied.
// ---------------------------------------------------------------------------
module tb_fp_align_stage;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        out_valid;
  logic        out_ready;
  logic        big_sign;
  logic        small_sign;
  logic [7:0]  exp_out;
  logic [23:0] big_mant;
  logic [26:0] small_mant;
  logic        swapped;
  logic        eff_sub;
`ifdef FP_ALIGN_SPECIAL_EN
  logic        is_nan;
  logic        is_inf;
  logic        is_zero;
`endif

  int vectors;
  int miscompares;

  localparam logic [31:0] SEQ_A [4] = '{32'h3F800000, 32'h40000000, 32'h3E800000, 32'h3F800000};
  localparam logic [31:0] SEQ_B [4] = '{32'h3F000000, 32'h3F800000, 32'h40400000, 32'h33800001};
  localparam logic [7:0]  E_EXP [4] = '{8'h7F, 8'h80, 8'h80, 8'h7F};
  localparam logic [23:0] E_BIG [4] = '{24'h800000, 24'h800000, 24'hC00000, 24'h800000};
  localparam logic [26:0] E_SML [4] = '{27'h2000000, 27'h2000000, 27'h0800000, 27'h0000005};
  localparam logic        E_SWP [4] = '{1'b0, 1'b0, 1'b1, 1'b0};

  fp_align_stage dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .op_a       (op_a),
    .op_b       (op_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .big_sign   (big_sign),
    .small_sign (small_sign),
    .exp_out    (exp_out),
    .big_mant   (big_mant),
    .small_mant (small_mant),
    .swapped    (swapped),
    .eff_sub    (eff_sub)
`ifdef FP_ALIGN_SPECIAL_EN
    ,
    .is_nan     (is_nan),
    .is_inf     (is_inf),
    .is_zero    (is_zero)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Sends one operand pair into an idle pipeline and waits, bounded, for the
  // result. lat is the number of falling edges after the accepting edge.
  task automatic run_one(input logic [31:0] a, input logic [31:0] b, output int lat);
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    op_a      = a;
    op_b      = b;
    @(negedge clk);
    in_valid = 1'b0;
    lat      = 1;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    op_a      = '0;
    op_b      = '0;
    rst_n     = 1'b1;
    #1 rst_n  = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({out_valid, big_sign, small_sign, exp_out, big_mant, small_mant, swapped, eff_sub} !== '0)
      begin
        miscompares++;
        $display("[TB] FAIL reset_outputs: got valid=%b exp=%h big=%h small=%h expected all zero",
                 out_valid, exp_out, big_mant, small_mant);
      end
    rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready);
    end
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid);
    end
  endtask

  task automatic test_basic_align;
    int lat;
    run_one(32'h3F800000, 32'h3F000000, lat);
    vectors++;
    if (lat !== 2) begin
      miscompares++;
      $display("[TB] FAIL basic_latency: got %0d expected 2", lat);
    end
    vectors++;
    if ({exp_out, big_mant, small_mant, swapped, eff_sub} !==
        {8'h7F, 24'h800000, 27'h2000000, 1'b0, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL basic_align: got exp=%h big=%h small=%h swp=%b sub=%b expected exp=7f big=800000 small=2000000 swp=0 sub=0",
               exp_out, big_mant, small_mant, swapped, eff_sub);
    end
  endtask

  task automatic test_swap;
    int lat;
    run_one(32'h3F000000, 32'h3F800000, lat);
    vectors++;
    if (lat !== 2 || {exp_out, big_mant, small_mant, swapped, eff_sub} !==
        {8'h7F, 24'h800000, 27'h2000000, 1'b1, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL swap: got lat=%0d exp=%h big=%h small=%h swp=%b expected lat=2 exp=7f big=800000 small=2000000 swp=1",
               lat, exp_out, big_mant, small_mant, swapped);
    end
  endtask

  task automatic test_sticky_shift;
    int lat;
    run_one(32'h3F800000, 32'h33800001, lat);
    vectors++;
    if (lat !== 2 || small_mant !== 27'h0000005 || exp_out !== 8'h7F || swapped !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL sticky_shift: got small=%h exp=%h swp=%b expected small=0000005 exp=7f swp=0",
               small_mant, exp_out, swapped);
    end
  endtask

  task automatic test_sticky_flush;
    int lat;
    run_one(32'h3F800000, 32'h30000000, lat);
    vectors++;
    if (lat !== 2 || small_mant !== 27'h0000001 || big_mant !== 24'h800000) begin
      miscompares++;
      $display("[TB] FAIL sticky_flush: got small=%h big=%h expected small=0000001 big=800000",
               small_mant, big_mant);
    end
  endtask

  task automatic test_eff_sub;
    int lat;
    run_one(32'h3F800000, 32'hBF800000, lat);
    vectors++;
    if (lat !== 2 || {swapped, eff_sub, big_sign, small_sign} !== 4'b0101) begin
      miscompares++;
      $display("[TB] FAIL tie_signs: got swp=%b sub=%b bs=%b ss=%b expected swp=0 sub=1 bs=0 ss=1",
               swapped, eff_sub, big_sign, small_sign);
    end
    vectors++;
    if (small_mant !== 27'h4000000 || exp_out !== 8'h7F) begin
      miscompares++;
      $display("[TB] FAIL tie_mant: got small=%h exp=%h expected small=4000000 exp=7f",
               small_mant, exp_out);
    end
  endtask

  task automatic test_back_to_back;
    out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (c < 4) begin
        in_valid = 1'b1;
        op_a     = SEQ_A[c];
        op_b     = SEQ_B[c];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (c < 4) begin
        vectors++;
        if (in_ready !== 1'b1) begin
          miscompares++;
          $display("[TB] FAIL b2b_in_ready cycle %0d: got %b expected 1", c, in_ready);
        end
      end
      if (c >= 2 && c < 6) begin
        vectors++;
        if (out_valid !== 1'b1 || exp_out !== E_EXP[c-2] || big_mant !== E_BIG[c-2] ||
            small_mant !== E_SML[c-2] || swapped !== E_SWP[c-2]) begin
          miscompares++;
          $display("[TB] FAIL b2b_result %0d: got v=%b exp=%h big=%h small=%h swp=%b expected v=1 exp=%h big=%h small=%h swp=%b",
                   c - 2, out_valid, exp_out, big_mant, small_mant, swapped,
                   E_EXP[c-2], E_BIG[c-2], E_SML[c-2], E_SWP[c-2]);
        end
      end
      if (c >= 6) begin
        vectors++;
        if (out_valid !== 1'b0) begin
          miscompares++;
          $display("[TB] FAIL b2b_extra cycle %0d: got out_valid=%b expected 0", c, out_valid);
        end
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_backpressure;
    int          idx;
    int          out_idx;
    bit          stalled;
    logic [59:0] held;
    idx     = 0;
    out_idx = 0;
    stalled = 1'b0;
    held    = '0;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      out_ready = !(c >= 2 && c <= 5);
      in_valid  = (idx < 4);
      if (idx < 4) begin
        op_a = SEQ_A[idx];
        op_b = SEQ_B[idx];
      end
      #1;
      if (c >= 2 && c <= 5) begin
        vectors++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
          miscompares++;
          $display("[TB] FAIL bp_stall cycle %0d: got in_ready=%b out_valid=%b expected 0/1",
                   c, in_ready, out_valid);
        end
      end
      if (stalled) begin
        vectors++;
        if ({exp_out, big_mant, small_mant, swapped} !== held) begin
          miscompares++;
          $display("[TB] FAIL bp_hold cycle %0d: got %h expected %h", c,
                   {exp_out, big_mant, small_mant, swapped}, held);
        end
      end
      if (out_valid && out_ready) begin
        vectors++;
        if (out_idx >= 4) begin
          miscompares++;
          $display("[TB] FAIL bp_duplicate cycle %0d: got extra result exp=%h expected none", c, exp_out);
        end else if (exp_out !== E_EXP[out_idx] || big_mant !== E_BIG[out_idx] ||
                     small_mant !== E_SML[out_idx] || swapped !== E_SWP[out_idx]) begin
          miscompares++;
          $display("[TB] FAIL bp_order %0d: got exp=%h big=%h small=%h swp=%b expected exp=%h big=%h small=%h swp=%b",
                   out_idx, exp_out, big_mant, small_mant, swapped,
                   E_EXP[out_idx], E_BIG[out_idx], E_SML[out_idx], E_SWP[out_idx]);
        end
        out_idx++;
      end
      stalled = out_valid && !out_ready;
      held    = {exp_out, big_mant, small_mant, swapped};
      if (in_valid && in_ready) idx++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    vectors++;
    if (out_idx !== 4 || idx !== 4) begin
      miscompares++;
      $display("[TB] FAIL bp_count: got %0d out / %0d in expected 4 / 4", out_idx, idx);
    end
  endtask

  task automatic test_reset_midflight;
    bit leaked;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    op_a      = SEQ_A[0];
    op_b      = SEQ_B[0];
    @(negedge clk);
    op_a = SEQ_A[2];
    op_b = SEQ_B[2];
    @(negedge clk);
    in_valid = 1'b0;
    vectors++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL midrst_fill: got out_valid=%b in_ready=%b expected 1/0", out_valid, in_ready);
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({out_valid, big_sign, small_sign, exp_out, big_mant, small_mant, swapped, eff_sub} !== '0)
      begin
        miscompares++;
        $display("[TB] FAIL midrst_clear: got valid=%b exp=%h big=%h small=%h expected all zero",
                 out_valid, exp_out, big_mant, small_mant);
      end
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL midrst_in_ready: got %b expected 1", in_ready);
    end
    leaked = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) leaked = 1'b1;
    end
    vectors++;
    if (leaked) begin
      miscompares++;
      $display("[TB] FAIL midrst_discard: got out_valid after reset expected none");
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_basic_align();
    test_swap();
    test_sticky_shift();
    test_sticky_flush();
    test_eff_sub();
    test_back_to_back();
    test_backpressure();
    test_reset_midflight();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
